// File: rtl/uart_collector_pkg.sv
// rtl/uart_collector_pkg.sv - Shared FSM states, constants and divider helper for uart_collector.
package uart_collector_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   localparam logic [7:0] LF = 8'h0A;

   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_collector_fifo.sv
// rtl/uart_collector_fifo.sv - First-word-fall-through byte FIFO, 2**DEPTH_LOG2 entries.
module uart_collector_fifo #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_data,
   output logic       o_full,
   output logic       o_empty
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [7:0]          r_mem [DEPTH];
   logic [DEPTH_LOG2:0] r_wr_ptr;
   logic [DEPTH_LOG2:0] r_rd_ptr;
   logic                w_do_push;
   logic                w_do_pop;

   // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                      (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_collector.sv
// rtl/uart_collector.sv - 8N1 UART receiver feeding a byte stream through a small FIFO.
// Define UART_COLLECTOR_PARITY_EN to expect an even-parity bit between data and stop.
module uart_collector
   import uart_collector_pkg::*;
#(
   parameter int CLK_FREQ   = 16000000,
   parameter int BAUD       = 57600,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_rx,
   output logic [7:0] o_tdata,
   output logic       o_tlast,
   output logic       o_tvalid,
   input  logic       i_tready,
   output logic       o_overrun
);
   localparam int              DIV    = calc_div(CLK_FREQ, BAUD);
   localparam int              CW     = $clog2(DIV);
   localparam logic [CW-1:0]   C_HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0]   C_FULL = CW'(DIV - 1);

   logic          r_rx_meta;
   logic          r_rx_s;
   state_t        r_state;
   state_t        w_next_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_overrun;
   logic          w_tick;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_byte_ok;
   logic [7:0]    w_head;

`ifdef UART_COLLECTOR_PARITY_EN
   logic          r_par_bit;
   assign w_byte_ok = ~^{r_shift, r_par_bit};
`else
   assign w_byte_ok = 1'b1;
`endif

   assign w_tick = (r_cnt == '0);

   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      case (r_state)
         IDLE:  if (!r_rx_s) w_next_state = START;
         START: if (w_tick) w_next_state = r_rx_s ? IDLE : DATA;
         DATA: begin
            if (w_tick && r_bit_idx == 3'd7) begin
`ifdef UART_COLLECTOR_PARITY_EN
               w_next_state = PARITY;
`else
               w_next_state = STOP;
`endif
            end
         end
`ifdef UART_COLLECTOR_PARITY_EN
         PARITY: if (w_tick) w_next_state = STOP;
`endif
         STOP: begin
            if (w_tick) begin
               w_next_state = r_rx_s ? IDLE : BREAK;
               w_push       = r_rx_s && w_byte_ok;
            end
         end
         BREAK: if (r_rx_s) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_overrun <= 1'b0;
`ifdef UART_COLLECTOR_PARITY_EN
         r_par_bit <= 1'b0;
`endif
      end else begin
         r_rx_meta <= i_uart_rx;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_next_state;
         // Reload on every state change; otherwise free-run down, wrapping to a full bit time.
         if (w_next_state != r_state) r_cnt <= (w_next_state == START) ? C_HALF : C_FULL;
         else if (w_tick)             r_cnt <= C_FULL;
         else                         r_cnt <= r_cnt - 1'b1;
         if (r_state == START) begin
            r_bit_idx <= '0;
         end else if (r_state == DATA && w_tick) begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
         end
`ifdef UART_COLLECTOR_PARITY_EN
         if (r_state == PARITY && w_tick) r_par_bit <= r_rx_s;
`endif
         if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
      end
   end

   uart_collector_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (r_shift),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_pop     = !w_empty && i_tready;
   assign o_tvalid  = !w_empty;
   assign o_tdata   = w_empty ? 8'h00 : w_head;
   assign o_tlast   = !w_empty && (w_head == LF);
   assign o_overrun = r_overrun;

endmodule

// File: tb/tb_uart_collector.sv
// tb/tb_uart_collector.sv - Directed self-checking bench for uart_collector at DIV=16.
module tb_uart_collector;
   localparam int BT = 16;
`ifdef UART_COLLECTOR_PARITY_EN
   localparam int FIRST_LAT = 171;
`else
   localparam int FIRST_LAT = 155;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_uart_rx = 1'b1;
   logic [7:0] o_tdata;
   logic       o_tlast;
   logic       o_tvalid;
   logic       i_tready = 1'b0;
   logic       o_overrun;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         v_cycles = 0;
   int         first_valid_cyc = -1;
   int         start_cyc = 0;
   logic       prev_valid = 1'b0;
   logic [8:0] beats[$];

   uart_collector #(
      .CLK_FREQ   (16000000),
      .BAUD       (1000000),
      .DEPTH_LOG2 (2)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_uart_rx (i_uart_rx),
      .o_tdata   (o_tdata),
      .o_tlast   (o_tlast),
      .o_tvalid  (o_tvalid),
      .i_tready  (i_tready),
      .o_overrun (o_overrun)
   );

   initial forever #5 i_clk = ~i_clk;
   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   initial forever begin
      @(negedge i_clk);
      if (o_tvalid && i_tready) beats.push_back({o_tlast, o_tdata});
      if (o_tvalid) v_cycles++;
      if (o_tvalid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_valid = o_tvalid;
   end

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      i_uart_rx = b;
      repeat (BT) tick();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic p);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_COLLECTOR_PARITY_EN
      send_bit(p);
`else
      if (p === 1'bx) i_uart_rx = 1'b1;
`endif
      send_bit(1'b1);
   endtask

   task automatic clear_log();
      beats.delete();
      v_cycles = 0;
      first_valid_cyc = -1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_uart_rx = 1'b1;
      repeat (3) tick();
      n_cmp++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", o_tvalid); end
      n_cmp++; if (o_tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata: got %h want 00", o_tdata); end
      n_cmp++; if ({o_tlast, o_overrun} !== 2'b00) begin n_err++; $display("FAIL reset_tlast_overrun: got %b want 00", {o_tlast, o_overrun}); end
      i_rst = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_single_byte();
      i_tready = 1'b1;
      clear_log();
      send_byte(8'h55, 1'b0);
      repeat (10) tick();
      n_cmp++; if (beats.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", beats.size()); end
      n_cmp++; if (beats.size() < 1 || beats[0] !== 9'h055) begin n_err++; $display("FAIL single_beat: got %h want 055", beats.size() ? beats[0] : 9'h1ff); end
      n_cmp++; if (v_cycles !== 1) begin n_err++; $display("FAIL single_valid_len: got %0d want 1", v_cycles); end
      n_cmp++; if (first_valid_cyc - start_cyc !== FIRST_LAT) begin n_err++; $display("FAIL single_latency: got %0d want %0d", first_valid_cyc - start_cyc, FIRST_LAT); end
   endtask

   task automatic test_line_end();
      logic [8:0] exp [3];
      exp[0] = 9'h06F; exp[1] = 9'h06B; exp[2] = 9'h10A;
      i_tready = 1'b1;
      clear_log();
      send_byte(8'h6F, 1'b0);
      send_byte(8'h6B, 1'b1);
      send_byte(8'h0A, 1'b0);
      repeat (10) tick();
      n_cmp++; if (beats.size() !== 3) begin n_err++; $display("FAIL line_count: got %0d want 3", beats.size()); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (i >= beats.size() || beats[i] !== exp[i]) begin
            n_err++; $display("FAIL line_beat%0d: got %h want %h", i, (i < beats.size()) ? beats[i] : 9'h1ff, exp[i]);
         end
      end
   endtask

   task automatic test_overrun();
      i_tready = 1'b0;
      clear_log();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), ^8'(i));
      n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_before: got %b want 0", o_overrun); end
      send_byte(8'h05, 1'b0);
      repeat (4) tick();
      n_cmp++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_after: got %b want 1", o_overrun); end
      n_cmp++; if ({o_tvalid, o_tdata} !== 9'h101) begin n_err++; $display("FAIL ovr_head_stable: got %h want 101", {o_tvalid, o_tdata}); end
      i_tready = 1'b1;
      repeat (10) tick();
      n_cmp++; if (beats.size() !== 4) begin n_err++; $display("FAIL ovr_drain_count: got %0d want 4", beats.size()); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= beats.size() || beats[i] !== 9'(i + 1)) begin
            n_err++; $display("FAIL ovr_drain%0d: got %h want %h", i, (i < beats.size()) ? beats[i] : 9'h1ff, 9'(i + 1));
         end
      end
   endtask

   task automatic test_full_pop();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      i_tready = 1'b0;
      repeat (4) tick();
      clear_log();
      for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
      fork
         send_byte(8'h14, 1'b1);
         begin
            repeat (FIRST_LAT - 1) tick();
            i_tready = 1'b1;
            tick();
            i_tready = 1'b0;
         end
      join
      repeat (4) tick();
      n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL fullpop_overrun: got %b want 0", o_overrun); end
      i_tready = 1'b1;
      repeat (10) tick();
      n_cmp++; if (beats.size() !== 5) begin n_err++; $display("FAIL fullpop_count: got %0d want 5", beats.size()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= beats.size() || beats[i] !== 9'h010 + 9'(i)) begin
            n_err++; $display("FAIL fullpop_beat%0d: got %h want %h", i, (i < beats.size()) ? beats[i] : 9'h1ff, 9'h010 + 9'(i));
         end
      end
   endtask

   task automatic test_glitch_break();
      i_tready = 1'b1;
      clear_log();
      i_uart_rx = 1'b0;
      repeat (4) tick();
      i_uart_rx = 1'b1;
      repeat (3 * BT) tick();
      n_cmp++; if (beats.size() !== 0) begin n_err++; $display("FAIL glitch_beats: got %0d want 0", beats.size()); end
      i_uart_rx = 1'b0;
      repeat (30 * BT) tick();
      i_uart_rx = 1'b1;
      repeat (2 * BT) tick();
      send_byte(8'hA5, 1'b0);
      repeat (10) tick();
      n_cmp++; if (beats.size() !== 1) begin n_err++; $display("FAIL break_count: got %0d want 1", beats.size()); end
      n_cmp++; if (beats.size() < 1 || beats[0] !== 9'h0A5) begin n_err++; $display("FAIL break_beat: got %h want 0a5", beats.size() ? beats[0] : 9'h1ff); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'h3C;
      i_tready = 1'b0;
      clear_log();
      send_byte(8'h77, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      i_uart_rx = d[3];
      repeat (5) tick();
      i_rst = 1'b1;
      tick();
      n_cmp++; if ({o_tvalid, o_tlast, o_overrun} !== 3'b000) begin n_err++; $display("FAIL midrst_flags: got %b want 000", {o_tvalid, o_tlast, o_overrun}); end
      n_cmp++; if (o_tdata !== 8'h00) begin n_err++; $display("FAIL midrst_tdata: got %h want 00", o_tdata); end
      i_rst = 1'b0;
      i_uart_rx = 1'b1;
      repeat (20 * BT) tick();
      n_cmp++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_no_partial: got %b want 0", o_tvalid); end
      i_tready = 1'b1;
`ifdef UART_COLLECTOR_PARITY_EN
      send_byte(d, 1'b1);
      repeat (10) tick();
      n_cmp++; if (beats.size() !== 0) begin n_err++; $display("FAIL parity_bad_dropped: got %0d want 0", beats.size()); end
`endif
      send_byte(d, 1'b0);
      repeat (10) tick();
      n_cmp++; if (beats.size() !== 1) begin n_err++; $display("FAIL midrst_count: got %0d want 1", beats.size()); end
      n_cmp++; if (beats.size() < 1 || beats[0] !== 9'h03C) begin n_err++; $display("FAIL midrst_beat: got %h want 03c", beats.size() ? beats[0] : 9'h1ff); end
   endtask

   initial begin
      tick();
      test_reset();
      test_single_byte();
      test_line_end();
      test_overrun();
      test_full_pop();
      test_glitch_break();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_collector.md
Name: uart_collector

Overview:
- UART receiver: return path of the emitter. Deserialises an 8N1 serial line into bytes and presents them as an AXI-stream-style byte master (tdata/tlast/tvalid/tready).
- Sits between a board RX pin and a stream consumer, e.g. a command parser feeding corescorecore.
- A small FIFO absorbs consumer stalls. Bytes equal to newline are tagged with tlast so line-oriented consumers see message boundaries.

Parameters:
- CLK_FREQ, 16000000, input clock frequency in Hz
- BAUD, 57600, line rate in bit/s; DIV = CLK_FREQ/BAUD, integer division, must be >= 8
- DEPTH_LOG2, 2, FIFO holds 2**DEPTH_LOG2 bytes

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_uart_rx  in  1  asynchronous serial line, idle high
- o_tdata  out  8  byte at FIFO head
- o_tlast  out  1  head byte == 8'h0A
- o_tvalid  out  1  FIFO non-empty
- i_tready  in  1  consumer accepts head this cycle
- o_overrun  out  1  sticky: a received byte was dropped because the FIFO was full

Behaviour:
- One clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - o_tvalid=0, o_tdata=0, o_tlast=0, o_overrun=0
  - FIFO empty; FSM IDLE; synchroniser flops =1
  - Reset mid-frame abandons the frame with no partial push.
- i_uart_rx passes through a 2-flop synchroniser (rx_s) before any use.
- Baud counter width $clog2(DIV). It reloads on every state change and counts down to 0.
- FSM:
  - IDLE: on rx_s==0 -> START, counter=DIV/2-1.
  - START: at count 0, sample rx_s.
    - 0 -> DATA, bit index=0, counter=DIV-1.
    - 1 -> IDLE (glitch rejected).
  - DATA: at each count 0, shift rx_s into shift register MSB-first-in so that bit0 is received first (LSB first); reload DIV-1. After bit index 7 -> STOP (or PARITY if enabled).
  - STOP: at count 0, sample rx_s.
    - 1 -> push byte, go IDLE.
    - 0 -> framing error, discard byte, go BREAK.
  - BREAK: remain until rx_s==1, then IDLE. This prevents a held-low line from producing 8'h00 bytes.
- Push/pop:
  - Push occurs on the stop-sample cycle. o_tvalid rises the following cycle when the FIFO was empty.
  - Pop when o_tvalid && i_tready; the head advances the next cycle.
  - Push while full with no pop in the same cycle: byte dropped, o_overrun set to 1. It clears only on reset.
  - Push while full with a simultaneous pop: accepted, no overrun, occupancy unchanged.
  - Push and pop on an empty FIFO cannot coincide (o_tvalid=0).
- o_tdata and o_tlast are stable while o_tvalid && !i_tready.
- Pointers wrap modulo 2**DEPTH_LOG2. Full/empty is resolved with an extra pointer bit.

Optional Feature:
- Macro: UART_COLLECTOR_PARITY_EN.
- Defined:
  - After DATA, a PARITY state samples one bit at count 0, then goes to STOP.
  - Byte is pushed only if the stop bit is 1 and the XOR of data and parity bits is 0 (even parity).
  - Parity mismatch discards the byte. STOP then proceeds normally: stop=1 -> IDLE, stop=0 -> BREAK. Overrun is not flagged.
- Undefined: 8N1 only; no PARITY state is synthesised.

Decomposition:
- Shared package uart_collector_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - constant LF = 8'h0A
  - function computing DIV from CLK_FREQ and BAUD
- One sub-module: uart_collector_fifo, a synchronous FWFT FIFO with push/pop/full/empty, parameterised by DEPTH_LOG2.
- Synchroniser and FSM stay in the top module.

Test Plan:
- All tests use CLK_FREQ=16000000, BAUD=1000000 (DIV=16).
- Single byte: send 8'h55 with i_tready=1 -> exactly one beat, o_tdata=8'h55, o_tlast=0, o_tvalid high for 1 cycle, first asserted 1 cycle after the stop-bit sample.
- Line end: send "ok\n" with i_tready=1 -> beats 8'h6F, 8'h6B, 8'h0A, with o_tlast=1 only on 8'h0A.
- Backpressure/overrun: i_tready=0, send 5 bytes 8'h01..8'h05 -> FIFO holds 01..04, o_overrun=1 after byte 5. Then i_tready=1 -> exactly 01,02,03,04 delivered.
- Full plus simultaneous pop: FIFO full, assert i_tready for a single cycle coincident with the next stop sample -> byte accepted, o_overrun stays 0.
- Glitch/break:
  - 4-cycle low pulse -> no beat.
  - Line held low for 30 bit times, then idle, then 8'hA5 -> no 8'h00 beats; only 8'hA5 delivered.
- Reset mid-frame: assert i_rst during DATA bit 3 -> all outputs 0 next cycle; next full byte 8'h3C received correctly. With UART_COLLECTOR_PARITY_EN: 8'h3C with parity bit 1 dropped, with parity bit 0 delivered.
